// File: rtl/pong_referee.sv
// ----------------------------------------------------------------------------
// pong_referee
//   Game referee for a pong playfield. It watches the ball position and the
//   ball's edge-win flags, detects paddle contact, keeps both scores and runs
//   the IDLE -> SERVE -> PLAY -> POINT -> (SERVE | GAME_OVER) sequence. It
//   drives the ball block's contact pulses, re-centre and pause controls.
//
// Ports
//   clk            system clock, all logic on the rising edge
//   rst            synchronous active-low reset
//   start          one-cycle start / restart strobe
//   pause_req      user pause level
//   ball_x/ball_y  ball centre
//   win            ball edge flags: [0] right edge (left scores),
//                                   [1] left edge (right scores)
//   paddle_l_y     left paddle centre y
//   paddle_r_y     right paddle centre y
//   touchingPaddle registered contact pulse to the ball: [0] left, [1] right
//   ball_rst       active-high re-centre to the ball
//   pause          freeze to the ball
//   score_l/_r     player scores, saturating at WIN_SCORE
//   game_over      high while in GAME_OVER
//   winner         0 = left won, 1 = right won; valid while game_over
// ----------------------------------------------------------------------------
module pong_referee #(
  parameter int BIT_WIDTH     = 10,
  parameter int MAX_X         = 640,
  parameter int MAX_Y         = 480,
  parameter int BALL_RADIUS   = 8,
  parameter int PADDLE_X_L    = 16,
  parameter int PADDLE_X_R    = 624,
  parameter int PADDLE_HALF_W = 4,
  parameter int PADDLE_HALF_H = 32,
  parameter int SCORE_WIDTH   = 4,
  parameter int WIN_SCORE     = 7,
  parameter int SERVE_DELAY   = 60
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   pause_req,
  input  logic [BIT_WIDTH-1:0]   ball_x,
  input  logic [BIT_WIDTH-1:0]   ball_y,
  input  logic [1:0]             win,
  input  logic [BIT_WIDTH-1:0]   paddle_l_y,
  input  logic [BIT_WIDTH-1:0]   paddle_r_y,
  output logic [1:0]             touchingPaddle,
  output logic                   ball_rst,
  output logic                   pause,
  output logic [SCORE_WIDTH-1:0] score_l,
  output logic [SCORE_WIDTH-1:0] score_r,
  output logic                   game_over,
  output logic                   winner
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SERVE     = 3'd1;
  localparam logic [2:0] S_PLAY      = 3'd2;
  localparam logic [2:0] S_POINT     = 3'd3;
  localparam logic [2:0] S_GAME_OVER = 3'd4;

  // One extra bit keeps every sum below free of overflow.
  localparam int CW    = BIT_WIDTH + 1;
  localparam int CNT_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

  localparam logic [CNT_W-1:0]       CNT_LOAD = CNT_W'(SERVE_DELAY - 1);
  localparam logic [SCORE_WIDTH-1:0] WIN_S    = SCORE_WIDTH'(WIN_SCORE);

  // Overlap window constants. The lower x bound is written as
  // ball_x + (radius + half_w) >= paddle_x so nothing is ever subtracted.
  localparam logic [CW-1:0] L_X_HI  = CW'(PADDLE_X_L + PADDLE_HALF_W + BALL_RADIUS);
  localparam logic [CW-1:0] R_X_HI  = CW'(PADDLE_X_R + PADDLE_HALF_W + BALL_RADIUS);
  localparam logic [CW-1:0] L_X_REF = CW'(PADDLE_X_L);
  localparam logic [CW-1:0] R_X_REF = CW'(PADDLE_X_R);
  localparam logic [CW-1:0] X_REACH = CW'(BALL_RADIUS + PADDLE_HALF_W);
  localparam logic [CW-1:0] Y_REACH = CW'(PADDLE_HALF_H + BALL_RADIUS);

  logic [2:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [1:0]             win_cap_q, win_cap_d;
  logic [1:0]             arm_q, arm_d;
  logic [1:0]             touch_q, touch_d;
  logic                   ball_rst_q, ball_rst_d;
  logic                   pause_q, pause_d;
  logic [SCORE_WIDTH-1:0] score_l_q, score_l_d;
  logic [SCORE_WIDTH-1:0] score_r_q, score_r_d;
  logic                   game_over_q, game_over_d;
  logic                   winner_q, winner_d;

  logic [CW-1:0]          bx, by, ply, pry;
  logic                   ov_l, ov_r;
  logic [SCORE_WIDTH-1:0] inc_l, inc_r;
  logic                   contact_ok;

  // Paddle overlap, all compares at BIT_WIDTH+1 bits.
  always_comb begin
    bx   = {1'b0, ball_x};
    by   = {1'b0, ball_y};
    ply  = {1'b0, paddle_l_y};
    pry  = {1'b0, paddle_r_y};
    ov_l = (bx <= L_X_HI) && (bx + X_REACH >= L_X_REF) &&
           (by + Y_REACH >= ply) && (by <= ply + Y_REACH);
    ov_r = (bx <= R_X_HI) && (bx + X_REACH >= R_X_REF) &&
           (by + Y_REACH >= pry) && (by <= pry + Y_REACH);
  end

  // Saturating increments; the game ends at WIN_SCORE so the hold branch is
  // only a guard against wrap.
  assign inc_l = (score_l_q == WIN_S) ? score_l_q : score_l_q + 1'b1;
  assign inc_r = (score_r_q == WIN_S) ? score_r_q : score_r_q + 1'b1;

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    win_cap_d = win_cap_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    winner_d  = winner_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_SERVE;
          cnt_d     = CNT_LOAD;
          score_l_d = '0;
          score_r_d = '0;
        end
      end
      S_SERVE: begin
        // pause_req freezes the countdown, including on its last count.
        if (!pause_req) begin
          if (cnt_q == '0) state_d = S_PLAY;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      S_PLAY: begin
        if (win != 2'b00) begin
          state_d   = S_POINT;
          win_cap_d = win;
        end
      end
      S_POINT: begin
        state_d = S_SERVE;
        cnt_d   = CNT_LOAD;
        // 2'b11 is a replay: neither side scores.
        if (win_cap_q == 2'b01) begin
          score_l_d = inc_l;
          if (inc_l == WIN_S) begin
            state_d  = S_GAME_OVER;
            winner_d = 1'b0;
          end
        end else if (win_cap_q == 2'b10) begin
          score_r_d = inc_r;
          if (inc_r == WIN_S) begin
            state_d  = S_GAME_OVER;
            winner_d = 1'b1;
          end
        end
      end
      S_GAME_OVER: begin
        if (start) begin
          state_d   = S_SERVE;
          cnt_d     = CNT_LOAD;
          score_l_d = '0;
          score_r_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    ball_rst_d  = (state_d == S_IDLE) || (state_d == S_SERVE);
    game_over_d = (state_d == S_GAME_OVER);
    case (state_d)
      S_SERVE, S_PLAY:      pause_d = pause_req;
      S_POINT, S_GAME_OVER: pause_d = 1'b1;
      default:              pause_d = 1'b0;
    endcase

    // A win in the same cycle suppresses contact; PLAY is being left anyway.
    contact_ok = (state_q == S_PLAY) && (win == 2'b00) && !pause_req;
    touch_d[0] = contact_ok && arm_q[0] && ov_l;
    touch_d[1] = contact_ok && arm_q[1] && ov_r;

    // An arm is spent by its pulse and re-set once the overlap clears, so a
    // ball lingering inside the paddle bounces only once.
    if (state_q != S_PLAY) begin
      arm_d = 2'b11;
    end else begin
      arm_d[0] = touch_d[0] ? 1'b0 : (!ov_l ? 1'b1 : arm_q[0]);
      arm_d[1] = touch_d[1] ? 1'b0 : (!ov_r ? 1'b1 : arm_q[1]);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      win_cap_q   <= 2'b00;
      arm_q       <= 2'b11;
      touch_q     <= 2'b00;
      ball_rst_q  <= 1'b1;
      pause_q     <= 1'b0;
      score_l_q   <= '0;
      score_r_q   <= '0;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      win_cap_q   <= win_cap_d;
      arm_q       <= arm_d;
      touch_q     <= touch_d;
      ball_rst_q  <= ball_rst_d;
      pause_q     <= pause_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
    end
  end

  assign touchingPaddle = touch_q;
  assign ball_rst       = ball_rst_q;
  assign pause          = pause_q;
  assign score_l        = score_l_q;
  assign score_r        = score_r_q;
  assign game_over      = game_over_q;
  assign winner         = winner_q;

endmodule
